// File: rtl/bf16_norm_round.sv
// Normalize / round-to-nearest-even / pack unit producing a bf16 word and a one-hot class flag.
// Normalization moves one bit per cycle; one operation in flight, valid/ready on both sides.
module bf16_norm_round #(
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 7,
    parameter int FLAG_WIDTH = 4,
    parameter int MANT_WIDTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_sign,
    input  logic [EXP_WIDTH+1:0]           i_exp,
    input  logic [MANT_WIDTH-1:0]          i_mant,
    input  logic [FLAG_WIDTH-1:0]          i_flag,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0]   o_data,
    output logic [FLAG_WIDTH-1:0]          o_flag
);

    localparam int EW      = EXP_WIDTH + 2;
    localparam int DW      = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int MW      = MANT_WIDTH;
    localparam int LSB_POS = MW - 2 - SIG_WIDTH;
    localparam int GRD_POS = LSB_POS - 1;
    localparam int F_NAN   = 3;
    localparam int F_ZERO  = 2;
    localparam int F_INF   = 1;
    localparam int F_NORM  = 0;

    localparam logic [FLAG_WIDTH-1:0] FL_NAN  = FLAG_WIDTH'(1) << F_NAN;
    localparam logic [FLAG_WIDTH-1:0] FL_ZERO = FLAG_WIDTH'(1) << F_ZERO;
    localparam logic [FLAG_WIDTH-1:0] FL_INF  = FLAG_WIDTH'(1) << F_INF;
    localparam logic [FLAG_WIDTH-1:0] FL_NORM = FLAG_WIDTH'(1) << F_NORM;

    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_INF  = EW'((1 << EXP_WIDTH) - 1);

    localparam logic [MW-1:0] ROUND_INC = MW'(1) << LSB_POS;
    localparam logic [DW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 r_state, w_state_next;
    logic                   r_sign,  w_sign_next;
    logic signed [EW-1:0]   r_exp,   w_exp_next;
    logic [MW-1:0]          r_mant,  w_mant_next;
    logic [DW-1:0]          r_data,  w_data_next;
    logic [FLAG_WIDTH-1:0]  r_flag,  w_flag_next;
    logic                   r_valid, w_valid_next;

    logic                   w_round_up;
    logic [MW-1:0]          w_round_mant;
    logic                   w_round_carry;
    logic signed [EW-1:0]   w_round_exp;
    logic [SIG_WIDTH-1:0]   w_round_frac;
    logic                   w_unused;

    // Carry out of the increment lands in the top mantissa bit, so it is seen before the frac slice.
    assign w_round_up    = r_mant[GRD_POS] & ((|r_mant[GRD_POS-1:0]) | r_mant[LSB_POS]);
    assign w_round_mant  = w_round_up ? (r_mant + ROUND_INC) : r_mant;
    assign w_round_carry = w_round_mant[MW-1];
    assign w_round_exp   = w_round_carry ? (r_exp + EXP_ONE) : r_exp;
    assign w_round_frac  = w_round_carry ? '0 : w_round_mant[MW-3 -: SIG_WIDTH];
    assign w_unused      = ^{w_round_mant[MW-2], w_round_mant[LSB_POS-1:0], i_flag[F_NORM]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_data  <= '0;
            r_flag  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sign  <= w_sign_next;
            r_exp   <= w_exp_next;
            r_mant  <= w_mant_next;
            r_data  <= w_data_next;
            r_flag  <= w_flag_next;
            r_valid <= w_valid_next;
        end
    end

    // ROUND is entered on the same edge that completes normalization, giving 2+N latency.
    always_comb begin
        w_state_next = r_state;
        w_sign_next  = r_sign;
        w_exp_next   = r_exp;
        w_mant_next  = r_mant;
        w_data_next  = r_data;
        w_flag_next  = r_flag;
        w_valid_next = r_valid;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_sign_next = i_sign;
                    w_exp_next  = i_exp;
                    w_mant_next = i_mant;
                    if (i_flag[F_NAN]) begin
                        w_data_next  = QNAN;
                        w_flag_next  = FL_NAN;
                        w_valid_next = 1'b1;
                        w_state_next = S_DONE;
                    end else if (i_flag[F_INF]) begin
                        w_data_next  = {i_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
                        w_flag_next  = FL_INF;
                        w_valid_next = 1'b1;
                        w_state_next = S_DONE;
                    end else if (i_flag[F_ZERO] || (i_mant == '0)) begin
                        w_data_next  = {i_sign, {(DW-1){1'b0}}};
                        w_flag_next  = FL_ZERO;
                        w_valid_next = 1'b1;
                        w_state_next = S_DONE;
                    end else if (i_mant[MW-1:MW-2] == 2'b01) begin
                        w_state_next = S_ROUND;
                    end else begin
                        w_state_next = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (r_mant[MW-1]) begin
                    w_mant_next  = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
                    w_exp_next   = r_exp + EXP_ONE;
                    w_state_next = S_ROUND;
                end else if (!r_mant[MW-2]) begin
                    if (r_exp <= EXP_ONE) begin
                        w_data_next  = {r_sign, {(DW-1){1'b0}}};
                        w_flag_next  = FL_ZERO;
                        w_valid_next = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_mant_next = r_mant << 1;
                        w_exp_next  = r_exp - EXP_ONE;
                        if (r_mant[MW-3]) begin
                            w_state_next = S_ROUND;
                        end
                    end
                end else begin
                    w_state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                w_valid_next = 1'b1;
                w_state_next = S_DONE;
                if (w_round_exp >= EXP_INF) begin
                    w_data_next = {r_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
                    w_flag_next = FL_INF;
                end else if (w_round_exp <= EXP_ZERO) begin
                    w_data_next = {r_sign, {(DW-1){1'b0}}};
                    w_flag_next = FL_ZERO;
                end else begin
                    w_data_next = {r_sign, w_round_exp[EXP_WIDTH-1:0], w_round_frac};
                    w_flag_next = FL_NORM;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_flag  = r_flag;

endmodule

// File: tb/tb_bf16_norm_round.sv
// Randomized bench for bf16_norm_round with an arithmetic reference model and one output monitor.
module tb_bf16_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [9:0]  i_exp;
    logic [15:0] i_mant;
    logic [3:0]  i_flag;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic [3:0]  o_flag;

    always #5 clk = ~clk;

    bf16_norm_round dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sign  (i_sign),
        .i_exp   (i_exp),
        .i_mant  (i_mant),
        .i_flag  (i_flag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_flag  (o_flag)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        s;
        int          e;
        logic [15:0] m;
        logic [3:0]  f;
        logic [15:0] d;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_txn = 0;
    int   rdy_mode = 0;
    int   hold = 0;
    logic        prev_v = 1'b0;
    logic [15:0] last_d = '0;
    logic [3:0]  last_f = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value-level reference: leading-one position, integer rounding, range checks.
    function automatic void model(input logic s, input int e_in, input logic [15:0] m_in,
                                  input logic [3:0] f, output logic [15:0] d,
                                  output logic [3:0] fl, output int lat);
        int e, m, msb, k, kept, rem;
        e = e_in;
        m = int'(m_in);
        lat = 1;
        if (f[3]) begin d = 16'h7FC0; fl = 4'b1000; return; end
        if (f[1]) begin d = {s, 8'hFF, 7'h00}; fl = 4'b0010; return; end
        if (f[2] || m == 0) begin d = {s, 15'h0}; fl = 4'b0100; return; end
        if (m >= 32768) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            lat = 3;
        end else begin
            msb = 0;
            for (int b = 0; b < 16; b++) if (m_in[b]) msb = b;
            k = 14 - msb;
            if (k > 0 && e <= k) begin
                d = {s, 15'h0};
                fl = 4'b0100;
                lat = 2 + ((e > 1) ? e - 1 : 0);
                return;
            end
            m = m << k;
            e = e - k;
            lat = 2 + k;
        end
        kept = m >> 7;
        rem = m % 128;
        if (rem > 64 || (rem == 64 && kept % 2 == 1)) kept++;
        if (kept >= 256) begin e++; kept = 128; end
        if (e >= 255) begin d = {s, 8'hFF, 7'h00}; fl = 4'b0010; end
        else if (e <= 0) begin d = {s, 15'h0}; fl = 4'b0100; end
        else begin d = {s, 8'(e), 7'(kept % 128)}; fl = 4'b0001; end
    endfunction

    task automatic send(input logic s, input int e, input logic [15:0] m, input logic [3:0] f);
        exp_t x;
        int   w;
        @(negedge clk);
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = 10'(e);
        i_mant  = m;
        i_flag  = f;
        w = 0;
        while (!o_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 32'(o_ready), 32'd1);
            i_valid = 1'b0;
            return;
        end
        model(s, e, m, f, x.d, x.f, x.lat);
        x.acc = cyc + 1;
        q.push_back(x);
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || !o_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    // Compares every valid output to the model, checks stability while held and after handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            last_d = '0;
            last_f = '0;
            hold   = 0;
        end else if (o_valid) begin
            if (!prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    cur = q.pop_front();
                    n_txn++;
                    $display("txn %0d: data=%h flag=%b latency=%0d", n_txn, o_data, o_flag,
                             cyc - cur.acc + 1);
                    chk("data", 32'(o_data), 32'(cur.d));
                    chk("flag", 32'(o_flag), 32'(cur.f));
                    chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
                hold = 0;
            end else begin
                chk("hold_data", 32'(o_data), 32'(last_d));
                chk("hold_flag", 32'(o_flag), 32'(last_f));
                hold++;
            end
            chk("ready_in_done", 32'(o_ready), 32'd0);
            chk("flag_onehot", 32'($countones(o_flag)), 32'd1);
            last_d = o_data;
            last_f = o_flag;
            prev_v = 1'b1;
        end else begin
            chk("idle_data", 32'(o_data), 32'(last_d));
            chk("idle_flag", 32'(o_flag), 32'(last_f));
            prev_v = 1'b0;
        end
    end

    initial begin
        i_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       i_ready = 1'b1;
                2:       i_ready = 1'b0;
                default: i_ready = 1'($urandom % 2);
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[13];
        logic [15:0] md;
        logic [3:0]  mf;
        int          ml;
        int          w;
        int          r;
        int          e;
        logic [15:0] m;
        logic [3:0]  f;

        vecs = '{
            '{1'b0, 127, 16'h4000, 4'b0001, 16'h3F80, 4'b0001, 2},
            '{1'b0, 127, 16'h8000, 4'b0001, 16'h4000, 4'b0001, 3},
            '{1'b0, 130, 16'h0100, 4'b0001, 16'h3E00, 4'b0001, 8},
            '{1'b0, 127, 16'h4040, 4'b0001, 16'h3F80, 4'b0001, 2},
            '{1'b0, 127, 16'h40C0, 4'b0001, 16'h3F82, 4'b0001, 2},
            '{1'b0, 127, 16'h4041, 4'b0001, 16'h3F81, 4'b0001, 2},
            '{1'b0, 127, 16'h7FC0, 4'b0001, 16'h4000, 4'b0001, 2},
            '{1'b0, 254, 16'h8000, 4'b0001, 16'h7F80, 4'b0010, 3},
            '{1'b1, 1,   16'h2000, 4'b0001, 16'h8000, 4'b0100, 2},
            '{1'b0, 0,   16'h4000, 4'b0001, 16'h0000, 4'b0100, 2},
            '{1'b1, 127, 16'h1234, 4'b1000, 16'h7FC0, 4'b1000, 1},
            '{1'b1, 127, 16'h4000, 4'b0010, 16'hFF80, 4'b0010, 1},
            '{1'b1, 127, 16'h0000, 4'b0001, 16'h8000, 4'b0100, 1}
        };

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sign  = 1'b0;
        i_exp   = '0;
        i_mant  = '0;
        i_flag  = '0;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_flag", 32'(o_flag), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);

        foreach (vecs[i]) begin
            model(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].f, md, mf, ml);
            chk("model_data", 32'(md), 32'(vecs[i].d));
            chk("model_flag", 32'(mf), 32'(vecs[i].fl));
            chk("model_lat", 32'(ml), 32'(vecs[i].lat));
            send(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].f);
            drain();
        end

        // Downstream stalls for several cycles in DONE.
        rdy_mode = 2;
        send(1'b0, 127, 16'h40C0, 4'b0001);
        w = 0;
        while (!o_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("stall_valid_seen", 32'(o_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready", 32'(o_ready), 32'd0);
            chk("stall_valid", 32'(o_valid), 32'd1);
        end
        #1 chk("stall_hold_cycles", 32'(hold), 32'd5);
        rdy_mode = 0;
        drain();

        // Reset pulse while normalizing drops the transaction.
        send(1'b0, 130, 16'h0100, 4'b0001);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_flag", 32'(o_flag), 32'd0);
        chk("midrst_data", 32'(o_data), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        repeat (12) @(negedge clk);
        chk("midrst_no_valid", 32'(o_valid), 32'd0);

        rdy_mode = 1;
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom % 16);
            f = (r == 0) ? 4'b1000 : (r == 1) ? 4'b0010 : (r == 2) ? 4'b0100 : 4'b0001;
            m = ($urandom % 10 == 0) ? 16'h0000 : (16'($urandom) >> ($urandom % 16));
            e = ($urandom % 4 == 0) ? int'($urandom_range(0, 16)) - 3 : int'($urandom_range(0, 300));
            send(1'($urandom % 2), e, m, f);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
